// File: rtl/product_rescale_fifo.sv
// Q16.16 -> Q8.8 saturating rescaler feeding a first-word-fall-through FIFO.
// Optional macro ROUND_EN adds round-half-up before the >>> 8; otherwise the rescale floors.
module product_rescale_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [31:0]   entry_1,
    output logic          full,
    input  logic          rd,
    output logic [15:0]   output_1,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          sat,
    output logic          overflow,
    output logic          underflow
);

`ifdef ROUND_EN
    localparam logic [32:0] ROUND_ADD = 33'd128;
`else
    localparam logic [32:0] ROUND_ADD = 33'd0;
`endif
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Returns {clamped, q8_8}; the 33-bit sum keeps the rounding add from wrapping.
    function automatic logic [16:0] rescale(input logic [31:0] p);
        logic signed [32:0] s;
        logic signed [24:0] q;
        logic [16:0]        r;
        s = $signed({p[31], p}) + $signed(ROUND_ADD);
        q = 25'(s >>> 8);
        if (q > 25'sd32767) begin
            r = {1'b1, 16'h7FFF};
        end else if (q < -25'sd32768) begin
            r = {1'b1, 16'h8000};
        end else begin
            r = {1'b0, q[15:0]};
        end
        return r;
    endfunction

    logic [15:0]  mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         sat_r;
    logic         overflow_r;
    logic         underflow_r;
    logic [16:0]  rescaled_s;
    logic         wr_ok_s;
    logic         rd_ok_s;

    // Status derived from registered pointers, write rescale, and acceptance.
    always_comb begin
        rescaled_s = rescale(entry_1);
        empty      = (wr_ptr_r == rd_ptr_r);
        full       = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        count      = wr_ptr_r - rd_ptr_r;
        wr_ok_s    = wr && !full;
        rd_ok_s    = rd && !empty;
        output_1   = mem_r[rd_ptr_r[AW-1:0]];
        sat        = sat_r;
        overflow   = overflow_r;
        underflow  = underflow_r;
    end

    // Pointer and sticky-flag state; reset overrides any same-cycle strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            sat_r       <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (wr_ok_s && rescaled_s[16]) begin
                sat_r <= 1'b1;
            end
            if (wr && full) begin
                overflow_r <= 1'b1;
            end
            if (rd && empty) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Storage is never cleared; it is only written on accepted writes outside reset.
    always_ff @(posedge clk) begin
        if (reset && wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rescaled_s[15:0];
        end
    end

endmodule

// File: tb/tb_product_rescale_fifo.sv
// Directed plus randomized bench for product_rescale_fifo, checked against a queue model.
// Define ROUND_EN for both bench and RTL to exercise the rounding build.
module tb_product_rescale_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] entry_1 = 32'h0;
    logic        full;
    logic [15:0] output_1;
    logic        empty;
    logic [3:0]  count;
    logic        sat;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_m[$];
    logic        sat_m = 1'b0;
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;

    product_rescale_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .entry_1(entry_1), .full(full),
        .rd(rd), .output_1(output_1), .empty(empty), .count(count),
        .sat(sat), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference rescale with plain integer arithmetic: floor(P + R) / 256, then clamp.
    function automatic logic [16:0] model_rescale(input logic [31:0] p);
        longint v;
        longint q;
        v = longint'($signed(p));
`ifdef ROUND_EN
        v = v + 128;
`endif
        if (v >= 0) q = v / 256;
        else q = -((-v + 255) / 256);
        if (q > 32767) return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(q)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q_m.size()));
        chk("empty", 32'(empty), 32'(q_m.size() == 0));
        chk("full", 32'(full), 32'(q_m.size() == DEPTH));
        chk("sat", 32'(sat), 32'(sat_m));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(unf_m));
        if (q_m.size() != 0) chk("output_1", 32'(output_1), 32'(q_m[0]));
    endtask

    task automatic cycle(input logic rst_v, input logic wr_v, input logic rd_v, input logic [31:0] d);
        logic [16:0] r;
        bit was_full;
        bit was_empty;
        reset = rst_v; wr = wr_v; rd = rd_v; entry_1 = d;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            q_m.delete();
            sat_m = 1'b0; ovf_m = 1'b0; unf_m = 1'b0;
        end else begin
            was_full  = (q_m.size() == DEPTH);
            was_empty = (q_m.size() == 0);
            r = model_rescale(d);
            if (wr_v && was_full) ovf_m = 1'b1;
            if (rd_v && was_empty) unf_m = 1'b1;
            if (rd_v && !was_empty) void'(q_m.pop_front());
            if (wr_v && !was_full) begin
                q_m.push_back(r[15:0]);
                if (r[16]) sat_m = 1'b1;
            end
        end
        reset = 1'b1; wr = 1'b0; rd = 1'b0;
        check_all();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] rv;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // basic rescale
        cycle(1'b1, 1'b1, 1'b0, 32'h001EE000);
        chk("basic_out", 32'(output_1), 32'h1EE0);
        chk("basic_cnt", 32'(count), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        chk("basic_empty", 32'(empty), 32'd1);

        // rounding boundary
        cycle(1'b1, 1'b1, 1'b0, 32'h00000180);
`ifdef ROUND_EN
        chk("round_pos", 32'(output_1), 32'h0002);
`else
        chk("round_pos", 32'(output_1), 32'h0001);
`endif
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'hFFFFFF80);
`ifdef ROUND_EN
        chk("round_neg", 32'(output_1), 32'h0000);
`else
        chk("round_neg", 32'(output_1), 32'hFFFF);
`endif
        cycle(1'b1, 1'b0, 1'b1, 32'h0);

        // saturation
        cycle(1'b1, 1'b1, 1'b0, 32'h7FFFFFFF);
        chk("sat_pos", 32'(output_1), 32'h7FFF);
        chk("sat_flag", 32'(sat), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h80000000);
        chk("sat_neg", 32'(output_1), 32'h8000);
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h007FFF00);
        chk("max_exact", 32'(output_1), 32'h7FFF);
        chk("sat_sticky", 32'(sat), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("sat_cleared", 32'(sat), 32'd0);

        // full, overflow, ordered drain
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h00000100 * k);
            if (k == 8) chk("full_at8", 32'(full), 32'd1);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("cnt_8", 32'(count), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            chk("drain_order", 32'(output_1), 32'(k));
            cycle(1'b1, 1'b0, 1'b1, 32'h0);
        end
        chk("drained", 32'(empty), 32'd1);
        for (int k = 10; k < 30; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h00000100 * k);
            chk("wrap_order", 32'(output_1), 32'(k));
            cycle(1'b1, 1'b0, 1'b1, 32'h0);
        end

        // simultaneous rd/wr at full, empty and mid occupancy
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b1, 1'b0, 32'h00000100 * k);
        cycle(1'b1, 1'b1, 1'b1, 32'h00004200);
        chk("sim_full_cnt", 32'(count), 32'd7);
        chk("sim_full_ovf", 32'(overflow), 32'd1);
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h00002500);
        chk("sim_empty_cnt", 32'(count), 32'd1);
        chk("sim_empty_unf", 32'(underflow), 32'd1);
        chk("sim_empty_out", 32'(output_1), 32'h0025);
        cycle(1'b1, 1'b1, 1'b0, 32'h00002600);
        cycle(1'b1, 1'b1, 1'b0, 32'h00002700);
        cycle(1'b1, 1'b1, 1'b1, 32'h00002800);
        chk("sim_mid_cnt", 32'(count), 32'd3);

        // reset mid-operation with a concurrent write
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b1, 1'b0, 32'h7FFFFFFF);
        cycle(1'b1, 1'b1, 1'b0, 32'h80000000);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h00001100);
        chk("mrst_cnt", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_full", 32'(full), 32'd0);
        chk("mrst_flags", {29'd0, sat, overflow, underflow}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'h00003300);
        chk("mrst_next", 32'(output_1), 32'h0033);

        // randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            rv = $urandom;
            case ($urandom_range(0, 3))
                0: d = rv;
                1: d = {{9{rv[22]}}, rv[22:0]};
                2: d = {{24{rv[7]}}, rv[7:0]};
                default: d = (rv[0] ? 32'h007FFF80 : 32'hFF7FFF7F) + 32'($urandom_range(0, 2));
            endcase
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 50), d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
